// File: rtl/cnt_ctrl_pkg.sv
// Shared types for the counter load arbiter: FSM state encoding and default data width.
package cnt_ctrl_pkg;
  localparam int CNT_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter, combinational: a lone request always wins; on contention ptr_i picks the winner (0 -> req0).
module rr_arb2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       ptr_i,
  output logic [1:0] win_o
);
  always_comb begin
    win_o = 2'b00;
    if (req0_i && (!req1_i || !ptr_i)) begin
      win_o = 2'b01;
    end else if (req1_i) begin
      win_o = 2'b10;
    end
  end
endmodule

// File: rtl/cnt_load_arb.sv
// Arbitrates two load requesters onto a shared counter, loads it, then checks the counter shows the value.
// All outputs registered; requests are held until granted. CNT_ARB_RR_EN selects round robin, else req0 has priority.
module cnt_load_arb
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] count,
  output logic             gnt0,
  output logic             gnt1,
  output logic             load,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wrap
);
  state_t           state_q;
  logic             gnt0_q, gnt1_q, load_q, busy_q, done_q, err_q, wrap_q;
  logic [WIDTH-1:0] d_q, prev_count_q;
  logic [WIDTH-1:0] d_d;
  logic             wrap_d;
  logic [1:0]       win;
  logic             ptr;

  rr_arb2 u_arb (
    .req0_i (req0),
    .req1_i (req1),
    .ptr_i  (ptr),
    .win_o  (win)
  );

`ifdef CNT_ARB_RR_EN
  logic ptr_q;
  // After granting req0 prefer req1 next, and vice versa.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (state_q == IDLE && win != 2'b00) begin
      ptr_q <= win[0];
    end
  end
  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  assign d_d = win[0] ? d0 : d1;
  // In CHECK the counter has just taken a load, so an F->0 step there is not a wrap.
  assign wrap_d = (state_q != CHECK) && (&prev_count_q) && (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wrap_q       <= 1'b0;
      d_q          <= '0;
      prev_count_q <= '0;
    end else begin
      prev_count_q <= count;
      wrap_q       <= wrap_d;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      load_q       <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win != 2'b00) begin
            gnt0_q  <= win[0];
            gnt1_q  <= win[1];
            load_q  <= 1'b1;
            d_q     <= d_d;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          state_q <= CHECK;
        end
        CHECK: begin
          if (count == d_q) begin
            done_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign load = load_q;
  assign d    = d_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_cnt_load_arb.sv
// Scoreboard bench for cnt_load_arb: directed requests push expected grant/done/wrap events; a negedge monitor pops them.
module tb_cnt_load_arb;
  localparam int W        = 4;
  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_WRAP  = 2;
`ifdef CNT_ARB_RR_EN
  localparam int N_ALT = 4;
  localparam bit RR    = 1'b1;
`else
  localparam int N_ALT = 3;
  localparam bit RR    = 1'b0;
`endif

  typedef struct {
    int         kind;
    logic [1:0] who;
    logic [W-1:0] val;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0, count = '0;
  logic         gnt0, gnt1, load, busy, done, err, wrap;
  logic [W-1:0] d;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cnt_mode = 0;   // 0: loadable hold, 1: ignores load, 2: free-running with load
  bit  hold_reqs = 1'b0;

  cnt_load_arb #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .d0    (d0),
    .req1  (req1),
    .d1    (d1),
    .count (count),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .load  (load),
    .d     (d),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [1:0] who, input logic [W-1:0] val);
    ev_t e;
    e.kind = kind;
    e.who  = who;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string name, input int kind, input logic [1:0] who,
                         input logic [W-1:0] val, input logic ld);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event kind=%0d who=%b d=%h at %0t", name, kind, who, val, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.who !== who || e.val !== val || ld !== (kind == EV_GRANT)) begin
        errors++;
        $display("FAIL %s: got kind=%0d who=%b d=%h load=%b, want kind=%0d who=%b d=%h at %0t",
                 name, kind, who, val, ld, e.kind, e.who, e.val, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (load || gnt0 || gnt1) pop_cmp("grant", EV_GRANT, {gnt1, gnt0}, d, load);
    if (done) pop_cmp("done", EV_DONE, 2'b00, '0, 1'b0);
    if (wrap) pop_cmp("wrap", EV_WRAP, 2'b00, '0, 1'b0);
  end

  // One clock; the counter model and requesters react 1 time unit after the edge.
  task automatic tick();
    logic         ld;
    logic [W-1:0] dv;
    ld = load;
    dv = d;
    @(posedge clk);
    #1;
    case (cnt_mode)
      0: if (ld === 1'b1) count = dv;
      2: count = (ld === 1'b1) ? dv : count + 1'b1;
      default: ;
    endcase
    if (!hold_reqs) begin
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_gnt0"}, gnt0, 0);
    chk({pfx, "_gnt1"}, gnt1, 0);
    chk({pfx, "_load"}, load, 0);
    chk({pfx, "_d"},    d,    0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_err"},  err,  0);
    chk({pfx, "_wrap"}, wrap, 0);
  endtask

  task automatic reset_dut();
    req0 = 1'b0;
    req1 = 1'b0;
    hold_reqs = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    count = '0;
    cnt_mode = 0;
  endtask

  initial begin
    reset = 1'b1;
    tick();
    chk_all_zero("rst");
    reset_dut();
    tick();
    chk_all_zero("idle");

    // Single req0 load, counter follows.
    req0 = 1'b1; d0 = 4'h9;
    expect_ev(EV_GRANT, 2'b01, 4'h9);
    expect_ev(EV_DONE, 2'b00, '0);
    tick();
    chk("a_busy_load", busy, 1);
    tick();
    chk("a_check_load", load, 0);
    chk("a_check_d", d, 4'h9);
    chk("a_check_busy", busy, 1);
    tick();
    chk("a_done", done, 1);
    chk("a_err", err, 0);
    chk("a_busy_idle", busy, 0);
    tick();

    // Both requesters held through every IDLE.
    reset_dut();
    hold_reqs = 1'b1; req0 = 1'b1; req1 = 1'b1; d0 = 4'h3; d1 = 4'hC;
    for (int k = 0; k < N_ALT; k++) begin
      if (RR && (k % 2 == 1)) expect_ev(EV_GRANT, 2'b10, 4'hC);
      else                    expect_ev(EV_GRANT, 2'b01, 4'h3);
      expect_ev(EV_DONE, 2'b00, '0);
    end
    for (int k = 0; k < N_ALT; k++) begin
      tick();
      if (k == N_ALT - 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      tick();
      tick();
    end
    hold_reqs = 1'b0;
    tick();

    // Counter ignores the load: err sets and is sticky.
    reset_dut();
    cnt_mode = 1; count = 4'h2;
    req1 = 1'b1; d1 = 4'h5;
    expect_ev(EV_GRANT, 2'b10, 4'h5);
    tick(); tick(); tick();
    chk("c_err_set", err, 1);
    chk("c_no_done", done, 0);
    cnt_mode = 0;
    req0 = 1'b1; d0 = 4'h2;
    expect_ev(EV_GRANT, 2'b01, 4'h2);
    expect_ev(EV_DONE, 2'b00, '0);
    tick(); tick(); tick();
    chk("c_err_sticky", err, 1);
    tick();
    reset_dut();
    chk("c_err_cleared", err, 0);

    // Free-running wrap, then a load of 0 from F that must not wrap.
    cnt_mode = 2; count = 4'hE;
    expect_ev(EV_WRAP, 2'b00, '0);
    tick(); tick(); tick();
    chk("d_wrap", wrap, 1);
    tick(); tick(); tick(); tick();
    cnt_mode = 0; count = 4'hF;
    tick();
    req0 = 1'b1; d0 = 4'h0;
    expect_ev(EV_GRANT, 2'b01, 4'h0);
    expect_ev(EV_DONE, 2'b00, '0);
    tick(); tick(); tick();
    chk("d_load_no_wrap", wrap, 0);
    chk("d_load_done", done, 1);
    tick(); tick();

    // Reset lands in LOAD, then req1 alone.
    req0 = 1'b1; d0 = 4'h7;
    expect_ev(EV_GRANT, 2'b01, 4'h7);
    tick();
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk_all_zero("abort");
    req0 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; count = '0;
    req1 = 1'b1; d1 = 4'hA;
    expect_ev(EV_GRANT, 2'b10, 4'hA);
    expect_ev(EV_DONE, 2'b00, '0);
    tick();
    chk("e_gnt1", gnt1, 1);
    chk("e_gnt0", gnt0, 0);
    tick(); tick();
    chk("e_err", err, 0);
    chk("e_done", done, 1);
    tick(); tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
